// File: rtl/cache_pkg.sv
// Shared types and address helpers for the L1 instruction cache.
package cache_pkg;

    localparam int unsigned ADDR_BITS     = 64;
    localparam int unsigned LINE_BITS     = 512;
    localparam int unsigned WORD_BITS     = 32;
    localparam int unsigned OFFSET_BITS   = 6;
    localparam int unsigned WORD_SEL_BITS = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        RESP
    } icache_state_t;

    // Index/tag are returned right-aligned in 64 bits; callers truncate to their width.
    function automatic logic [ADDR_BITS-1:0] addr_tag(input logic [ADDR_BITS-1:0] addr,
                                                      input int unsigned index_size);
        return addr >> (OFFSET_BITS + index_size);
    endfunction

    function automatic logic [ADDR_BITS-1:0] addr_index(input logic [ADDR_BITS-1:0] addr,
                                                        input int unsigned index_size);
        return (addr >> OFFSET_BITS) & ((ADDR_BITS'(1) << index_size) - ADDR_BITS'(1));
    endfunction

    function automatic logic [WORD_SEL_BITS-1:0] addr_word(input logic [ADDR_BITS-1:0] addr);
        return WORD_SEL_BITS'(addr >> 2);
    endfunction

    function automatic logic [WORD_BITS-1:0] select_word(input logic [LINE_BITS-1:0] line,
                                                         input logic [WORD_SEL_BITS-1:0] k);
        return line[{k, 5'b00000} +: WORD_BITS];
    endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage: one asynchronous read port, one write port, synchronous clear-all.
module icache_array
    import cache_pkg::*;
#(
    parameter int unsigned LINE_COUNT = 64,
    parameter int unsigned INDEX_SIZE = 6,
    parameter int unsigned TAG_SIZE   = 52
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_all_i,
    input  logic [INDEX_SIZE-1:0] rd_index_i,
    output logic                  rd_valid_o,
    output logic [TAG_SIZE-1:0]   rd_tag_o,
    output logic [LINE_BITS-1:0]  rd_line_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_SIZE-1:0] wr_index_i,
    input  logic [TAG_SIZE-1:0]   wr_tag_i,
    input  logic [LINE_BITS-1:0]  wr_line_i
);

    logic [LINE_COUNT-1:0] valid_q;
    logic [TAG_SIZE-1:0]   tag_q  [LINE_COUNT];
    logic [LINE_BITS-1:0]  data_q [LINE_COUNT];

    // Clear-all wins over a fill in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || clear_all_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_line_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_line_o  = data_q[rd_index_i];

endmodule

// File: rtl/l1_icache.sv
// Direct-mapped read-only L1 instruction cache: fetch FSM, miss handshake to the LLC, flush.
module l1_icache
    import cache_pkg::*;
#(
    parameter int unsigned LINE_COUNT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [63:0]          F_ADDR,
    input  logic                 F_ADDR_VALID,
    output logic                 F_ADDR_READY,
    output logic [31:0]          F_DATA,
    output logic                 F_DATA_VALID,
    input  logic                 F_DATA_READY,
    input  logic                 FLUSH,
    output logic [63:0]          L_R_ADDR,
    output logic                 L_R_ADDR_VALID,
    input  logic                 L_R_ADDR_READY,
    input  logic [LINE_BITS-1:0] L_R_DATA,
    input  logic                 L_R_DATA_VALID,
    output logic                 L_R_DATA_READY
);

    localparam int unsigned BYTES_PER_LINE = 64;
    localparam int unsigned INDEX_SIZE     = $clog2(LINE_COUNT);
    localparam int unsigned OFFSET_SIZE    = $clog2(BYTES_PER_LINE);
    localparam int unsigned TAG_SIZE       = 64 - INDEX_SIZE - OFFSET_SIZE;

    icache_state_t state_q, state_d;
    logic [63:0]   addr_q, addr_d;
    logic [31:0]   f_data_q, f_data_d;
    logic [63:0]   l_r_addr_q, l_r_addr_d;
    logic          flush_pending_q, flush_pending_d;

    logic                  rd_valid;
    logic [TAG_SIZE-1:0]   rd_tag;
    logic [LINE_BITS-1:0]  rd_line;
    logic                  wr_en;
    logic                  clear_all;

    logic [INDEX_SIZE-1:0]    req_index;
    logic [TAG_SIZE-1:0]      req_tag;
    logic [WORD_SEL_BITS-1:0] req_word;

    assign req_index = INDEX_SIZE'(addr_index(addr_q, INDEX_SIZE));
    assign req_tag   = TAG_SIZE'(addr_tag(addr_q, INDEX_SIZE));
    assign req_word  = addr_word(addr_q);

    icache_array #(
        .LINE_COUNT (LINE_COUNT),
        .INDEX_SIZE (INDEX_SIZE),
        .TAG_SIZE   (TAG_SIZE)
    ) u_array (
        .clk         (clk),
        .reset       (reset),
        .clear_all_i (clear_all),
        .rd_index_i  (req_index),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_line_o   (rd_line),
        .wr_en_i     (wr_en),
        .wr_index_i  (req_index),
        .wr_tag_i    (req_tag),
        .wr_line_i   (L_R_DATA)
    );

    // A flush pulse arriving in IDLE blocks the handshake in that same cycle.
    assign F_ADDR_READY = (state_q == IDLE) && !flush_pending_q && !FLUSH;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            f_data_q        <= '0;
            l_r_addr_q      <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            f_data_q        <= f_data_d;
            l_r_addr_q      <= l_r_addr_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        f_data_d        = f_data_q;
        l_r_addr_d      = l_r_addr_q;
        flush_pending_d = flush_pending_q | FLUSH;
        wr_en           = 1'b0;
        clear_all       = 1'b0;

        case (state_q)
            IDLE: begin
                if (flush_pending_q) begin
                    clear_all       = 1'b1;
                    flush_pending_d = FLUSH;
                end else if (F_ADDR_VALID && F_ADDR_READY) begin
                    addr_d  = F_ADDR;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (rd_valid && (rd_tag == req_tag)) begin
                    f_data_d = select_word(rd_line, req_word);
                    state_d  = RESP;
                end else begin
                    l_r_addr_d = {addr_q[63:OFFSET_SIZE], {OFFSET_SIZE{1'b0}}};
                    state_d    = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (L_R_ADDR_READY) begin
                    state_d = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                if (L_R_DATA_VALID) begin
                    wr_en    = 1'b1;
                    f_data_d = select_word(L_R_DATA, req_word);
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (F_DATA_READY) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign F_DATA         = f_data_q;
    assign F_DATA_VALID   = (state_q == RESP);
    assign L_R_ADDR       = l_r_addr_q;
    assign L_R_ADDR_VALID = (state_q == MISS_REQ);
    assign L_R_DATA_READY = (state_q == MISS_WAIT);

endmodule

// File: tb/tb_l1_icache.sv
// Directed, table-driven bench for l1_icache: hits, misses, conflicts, flushes, backpressure, reset.
module tb_l1_icache;

    logic         clk = 1'b0;
    logic         reset;
    logic [63:0]  F_ADDR;
    logic         F_ADDR_VALID;
    logic         F_ADDR_READY;
    logic [31:0]  F_DATA;
    logic         F_DATA_VALID;
    logic         F_DATA_READY;
    logic         FLUSH;
    logic [63:0]  L_R_ADDR;
    logic         L_R_ADDR_VALID;
    logic         L_R_ADDR_READY;
    logic [511:0] L_R_DATA;
    logic         L_R_DATA_VALID;
    logic         L_R_DATA_READY;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    l1_icache #(.LINE_COUNT(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .F_ADDR         (F_ADDR),
        .F_ADDR_VALID   (F_ADDR_VALID),
        .F_ADDR_READY   (F_ADDR_READY),
        .F_DATA         (F_DATA),
        .F_DATA_VALID   (F_DATA_VALID),
        .F_DATA_READY   (F_DATA_READY),
        .FLUSH          (FLUSH),
        .L_R_ADDR       (L_R_ADDR),
        .L_R_ADDR_VALID (L_R_ADDR_VALID),
        .L_R_ADDR_READY (L_R_ADDR_READY),
        .L_R_DATA       (L_R_DATA),
        .L_R_DATA_VALID (L_R_DATA_VALID),
        .L_R_DATA_READY (L_R_DATA_READY)
    );

    typedef struct {
        logic [63:0] addr;
        bit          miss;
        logic [63:0] laddr;
        logic [31:0] base;
        logic [31:0] exp_word;
        int          addr_stall;
        int          resp_stall;
        bit          flush_in_wait;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [511:0] make_line(input logic [31:0] base);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = base | 32'(k);
        return l;
    endfunction

    // Called and returns on a negedge.
    task automatic run_vec(input int idx, input vec_t v);
        int t;
        t = 0;
        while (!F_ADDR_READY && t < 8) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("v%0d addr_ready", idx), 64'(F_ADDR_READY), 64'd1);
        F_ADDR       = v.addr;
        F_ADDR_VALID = 1'b1;
        @(posedge clk);
        #1 F_ADDR_VALID = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d lookup_no_data", idx), 64'(F_DATA_VALID), 64'd0);
        @(negedge clk);
        check($sformatf("v%0d data_valid_n2", idx), 64'(F_DATA_VALID), 64'(!v.miss));
        check($sformatf("v%0d llc_req_n2", idx), 64'(L_R_ADDR_VALID), 64'(v.miss));
        if (v.miss) begin
            check($sformatf("v%0d llc_addr", idx), L_R_ADDR, v.laddr);
            for (int s = 0; s < v.addr_stall; s++) begin
                @(negedge clk);
                check($sformatf("v%0d stall_req_valid", idx), 64'(L_R_ADDR_VALID), 64'd1);
                check($sformatf("v%0d stall_req_addr", idx), L_R_ADDR, v.laddr);
            end
            L_R_ADDR_READY = 1'b1;
            @(posedge clk);
            #1 L_R_ADDR_READY = 1'b0;
            @(negedge clk);
            check($sformatf("v%0d data_ready", idx), 64'(L_R_DATA_READY), 64'd1);
            check($sformatf("v%0d req_dropped", idx), 64'(L_R_ADDR_VALID), 64'd0);
            if (v.flush_in_wait) begin
                FLUSH = 1'b1;
                @(posedge clk);
                #1 FLUSH = 1'b0;
                @(negedge clk);
                check($sformatf("v%0d still_waiting", idx), 64'(L_R_DATA_READY), 64'd1);
            end
            L_R_DATA       = make_line(v.base);
            L_R_DATA_VALID = 1'b1;
            @(posedge clk);
            #1 L_R_DATA_VALID = 1'b0;
            L_R_DATA = '0;
            @(negedge clk);
            check($sformatf("v%0d data_valid_m1", idx), 64'(F_DATA_VALID), 64'd1);
        end
        check($sformatf("v%0d word", idx), 64'(F_DATA), 64'(v.exp_word));
        for (int s = 0; s < v.resp_stall; s++) begin
            @(negedge clk);
            check($sformatf("v%0d stall_valid", idx), 64'(F_DATA_VALID), 64'd1);
            check($sformatf("v%0d stall_word", idx), 64'(F_DATA), 64'(v.exp_word));
            check($sformatf("v%0d stall_addr_ready", idx), 64'(F_ADDR_READY), 64'd0);
        end
        F_DATA_READY = 1'b1;
        @(posedge clk);
        #1 F_DATA_READY = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d released", idx), 64'(F_DATA_VALID), 64'd0);
    endtask

    initial begin
        //              addr                miss laddr               base          word          as rs fw
        vecs[0]  = '{64'h0000_0000_1000_0008, 1, 64'h0000_0000_1000_0000, 32'hA000_0000, 32'hA000_0002, 5, 0, 0};
        vecs[1]  = '{64'h0000_0000_1000_003C, 0, 64'h0,                   32'h0,         32'hA000_000F, 0, 4, 0};
        vecs[2]  = '{64'h0000_0000_1000_0013, 0, 64'h0,                   32'h0,         32'hA000_0004, 0, 0, 0};
        vecs[3]  = '{64'h0000_0000_1000_1000, 1, 64'h0000_0000_1000_1000, 32'hB000_0000, 32'hB000_0000, 0, 0, 0};
        vecs[4]  = '{64'h0000_0000_1000_0000, 1, 64'h0000_0000_1000_0000, 32'hA000_0000, 32'hA000_0000, 0, 0, 0};
        vecs[5]  = '{64'h0000_0000_2000_0044, 1, 64'h0000_0000_2000_0040, 32'hC000_0000, 32'hC000_0001, 1, 2, 0};
        vecs[6]  = '{64'h0000_0000_1000_0004, 0, 64'h0,                   32'h0,         32'hA000_0001, 0, 0, 0};
        vecs[7]  = '{64'h0000_0000_2000_0078, 0, 64'h0,                   32'h0,         32'hC000_000E, 0, 0, 0};
        vecs[8]  = '{64'h0000_0000_1000_0008, 1, 64'h0000_0000_1000_0000, 32'hA000_0000, 32'hA000_0002, 0, 0, 0};
        vecs[9]  = '{64'h0000_0000_2000_0040, 1, 64'h0000_0000_2000_0040, 32'hC000_0000, 32'hC000_0000, 0, 0, 0};
        vecs[10] = '{64'h0000_0000_3000_0080, 1, 64'h0000_0000_3000_0080, 32'hD000_0000, 32'hD000_0000, 0, 0, 1};
        vecs[11] = '{64'h0000_0000_3000_0084, 1, 64'h0000_0000_3000_0080, 32'hD000_0000, 32'hD000_0001, 0, 0, 0};
        vecs[12] = '{64'h0000_0000_3000_0088, 0, 64'h0,                   32'h0,         32'hD000_0002, 0, 0, 0};
        vecs[13] = '{64'h0000_0000_3000_0088, 1, 64'h0000_0000_3000_0080, 32'hE000_0000, 32'hE000_0002, 0, 0, 0};

        reset          = 1'b1;
        F_ADDR         = '0;
        F_ADDR_VALID   = 1'b0;
        F_DATA_READY   = 1'b0;
        FLUSH          = 1'b0;
        L_R_ADDR_READY = 1'b0;
        L_R_DATA       = '0;
        L_R_DATA_VALID = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        check("rst addr_ready", 64'(F_ADDR_READY), 64'd1);
        check("rst data_valid", 64'(F_DATA_VALID), 64'd0);
        check("rst data", 64'(F_DATA), 64'd0);
        check("rst llc_valid", 64'(L_R_ADDR_VALID), 64'd0);
        check("rst llc_addr", L_R_ADDR, 64'd0);
        check("rst data_ready", 64'(L_R_DATA_READY), 64'd0);

        for (int i = 0; i <= 7; i++) run_vec(i, vecs[i]);

        // Flush coinciding with a request: the flush wins, then one more blocked cycle.
        F_ADDR       = 64'h1000_0008;
        F_ADDR_VALID = 1'b1;
        FLUSH        = 1'b1;
        #1 check("flush_coincide ready", 64'(F_ADDR_READY), 64'd0);
        @(posedge clk);
        #1;
        FLUSH        = 1'b0;
        F_ADDR_VALID = 1'b0;
        @(negedge clk);
        check("flush_pending ready", 64'(F_ADDR_READY), 64'd0);
        check("flush_no_lookup", 64'(L_R_ADDR_VALID | F_DATA_VALID), 64'd0);
        @(negedge clk);
        check("flush_done ready", 64'(F_ADDR_READY), 64'd1);

        for (int i = 8; i <= 12; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a miss abandons it and clears the cache.
        F_ADDR       = 64'h5000_0000;
        F_ADDR_VALID = 1'b1;
        @(posedge clk);
        #1 F_ADDR_VALID = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midmiss req_valid", 64'(L_R_ADDR_VALID), 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midmiss rst llc_valid", 64'(L_R_ADDR_VALID), 64'd0);
        check("midmiss rst llc_addr", L_R_ADDR, 64'd0);
        check("midmiss rst addr_ready", 64'(F_ADDR_READY), 64'd1);

        run_vec(13, vecs[13]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
        $fatal(1);
    end

endmodule
